// File: rtl/stack_pkg.sv
// Shared types and defaults for the pin-level stack responder.
package stack_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 16;

    typedef enum logic [1:0] {
        OP_PUSH    = 2'd0,
        OP_POP     = 2'd1,
        OP_REPLACE = 2'd2
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Both requests seen on the same sampled cycle form a replace.
    function automatic op_e decode_op(input logic push, input logic pop);
        op_e op;
        if (push && pop) begin
            op = OP_REPLACE;
        end else if (push) begin
            op = OP_PUSH;
        end else begin
            op = OP_POP;
        end
        return op;
    endfunction

endpackage

// File: rtl/stack_if.sv
// Request/response bundle between the pin requester and the stack responder.
interface stack_if
    import stack_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             push_i;
    logic             pop_i;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic             instr_done;
    logic             full;
    logic             empty;
    logic             err;
    logic [CW-1:0]    count;

    modport master (
        output push_i, pop_i, data_in,
        input  data_out, instr_done, full, empty, err, count
    );

    modport slave (
        input  push_i, pop_i, data_in,
        output data_out, instr_done, full, empty, err, count
    );
endinterface

// File: rtl/stack_sync_2ff.sv
// Two-flop synchroniser for one asynchronous request level.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);
    logic meta_q;
    logic sync_q;

    // Resolve metastability over two stages before the FSM sees the level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule

// File: rtl/stack_core.sv
// LIFO responder: executes one push/pop/replace per 4-phase request handshake.
module stack_core
    import stack_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic    clk,
    input  logic    rst,
    stack_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic             push_s, pop_s;
    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [WIDTH-1:0] din_q, din_d;
    logic [CW-1:0]    sp_q, sp_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             err_q, err_d;
    logic             done_q, done_d;
    logic             wr_en_s;
    logic [AW-1:0]    wr_addr_s;
    logic [AW-1:0]    top_idx_s;
    logic [WIDTH-1:0] top_s;
    op_e              eff_op_s;
    logic [WIDTH-1:0] mem_q [DEPTH];

    sync_2ff u_sync_push (.clk(clk), .rst(rst), .d_i(bus.push_i), .q_o(push_s));
    sync_2ff u_sync_pop  (.clk(clk), .rst(rst), .d_i(bus.pop_i),  .q_o(pop_s));

    assign top_idx_s = AW'(sp_q - CW'(1));
    assign top_s     = mem_q[top_idx_s];

    // State register and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= OP_PUSH;
            din_q   <= '0;
            sp_q    <= '0;
            dout_q  <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            din_q   <= din_d;
            sp_q    <= sp_d;
            dout_q  <= dout_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    // Storage has no reset; a slot is always written before it can be read.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[wr_addr_s] <= din_q;
        end
    end

    // Next-state logic: DONE waits for both requests to be released.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (push_s || pop_s) state_d = S_EXEC;
                else                 state_d = S_IDLE;
            end
            S_EXEC:  state_d = S_DONE;
            S_DONE: begin
                if (!push_s && !pop_s) state_d = S_IDLE;
                else                   state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output and datapath next values; a replace on an empty stack acts as a push.
    always_comb begin
        op_d      = op_q;
        din_d     = din_q;
        sp_d      = sp_q;
        dout_d    = dout_q;
        err_d     = err_q;
        wr_en_s   = 1'b0;
        wr_addr_s = sp_q[AW-1:0];
        done_d    = (state_d == S_DONE);
        if (op_q == OP_REPLACE && sp_q == '0) eff_op_s = OP_PUSH;
        else                                  eff_op_s = op_q;
        case (state_q)
            S_IDLE: begin
                if (push_s || pop_s) begin
                    op_d  = decode_op(push_s, pop_s);
                    din_d = bus.data_in;
                end else begin
                    op_d  = op_q;
                    din_d = din_q;
                end
            end
            S_EXEC: begin
                case (eff_op_s)
                    OP_PUSH: begin
                        dout_d = din_q;
                        if (sp_q == FULL_CNT) begin
                            err_d = 1'b1;
                        end else begin
                            wr_en_s = 1'b1;
                            sp_d    = sp_q + CW'(1);
                            err_d   = 1'b0;
                        end
                    end
                    OP_POP: begin
                        if (sp_q == '0) begin
                            dout_d = '0;
                            err_d  = 1'b1;
                        end else begin
                            sp_d   = sp_q - CW'(1);
                            dout_d = top_s;
                            err_d  = 1'b0;
                        end
                    end
                    OP_REPLACE: begin
                        wr_en_s   = 1'b1;
                        wr_addr_s = top_idx_s;
                        dout_d    = top_s;
                        err_d     = 1'b0;
                    end
                    default: err_d = err_q;
                endcase
            end
            S_DONE:  done_d = (state_d == S_DONE);
            default: done_d = 1'b0;
        endcase
    end

    assign bus.data_out   = dout_q;
    assign bus.instr_done = done_q;
    assign bus.err        = err_q;
    assign bus.count      = sp_q;
    assign bus.full       = (sp_q == FULL_CNT);
    assign bus.empty      = (sp_q == '0);
endmodule

// File: tb/tb_stack_core.sv
// Randomised scoreboard bench for stack_core against a queue-based LIFO model.
module tb_stack_core;
    import stack_pkg::*;

    localparam int W = 8;
    localparam int D = 16;

    typedef struct {
        logic [7:0] data;
        logic       err;
        int         cnt;
        string      name;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];
    logic [7:0] model[$];

    always #5 clk = ~clk;

    stack_if #(.WIDTH(W), .DEPTH(D)) bus ();
    stack_core #(.WIDTH(W), .DEPTH(D)) dut (.clk(clk), .rst(rst), .bus(bus));

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endfunction

    // Reference LIFO: decides the expected response before the request is raised.
    function automatic void model_op(input bit p, input bit q, input logic [7:0] d, input string name);
        exp_t e;
        e.name = name;
        e.err  = 1'b0;
        if (p && q && model.size() > 0) begin
            e.data = model[model.size()-1];
            model[model.size()-1] = d;
        end else if (p) begin
            e.data = d;
            if (model.size() < D) model.push_back(d);
            else e.err = 1'b1;
        end else if (model.size() > 0) begin
            e.data = model.pop_back();
        end else begin
            e.data = 8'h00;
            e.err  = 1'b1;
        end
        e.cnt = model.size();
        exp_q.push_back(e);
    endfunction

    task automatic wait_level(input logic lvl, input int bound, input string name);
        int n = 0;
        while (bus.instr_done !== lvl && n < bound) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'd0, bus.instr_done}, {31'd0, lvl});
    endtask

    task automatic do_op(input bit p, input bit q, input logic [7:0] d, input string name,
                         input int hold, input int fall_bound);
        model_op(p, q, d, name);
        @(negedge clk);
        bus.data_in = d;
        bus.push_i  = p;
        bus.pop_i   = q;
        wait_level(1'b1, 20, {name, "_rise"});
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({name, "_held"}, {31'd0, bus.instr_done}, 32'd1);
        end
        if (hold > 0) check({name, "_single_exec"}, 32'(bus.count), 32'(model.size()));
        @(negedge clk);
        bus.push_i = 1'b0;
        bus.pop_i  = 1'b0;
        wait_level(1'b0, fall_bound, {name, "_fall"});
    endtask

    // Monitor: compares each completed operation against the oldest expectation.
    initial begin
        logic prev = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.instr_done === 1'b1 && prev !== 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check({e.name, "_data"},  32'(bus.data_out), 32'(e.data));
                    check({e.name, "_err"},   {31'd0, bus.err}, {31'd0, e.err});
                    check({e.name, "_count"}, 32'(bus.count), 32'(e.cnt));
                    check({e.name, "_full"},  {31'd0, bus.full}, {31'd0, (e.cnt == D)});
                    check({e.name, "_empty"}, {31'd0, bus.empty}, {31'd0, (e.cnt == 0)});
                end
            end
            prev = bus.instr_done;
        end
    end

    task automatic check_reset_values(input string name);
        check({name, "_data"},  32'(bus.data_out), 32'd0);
        check({name, "_done"},  {31'd0, bus.instr_done}, 32'd0);
        check({name, "_err"},   {31'd0, bus.err}, 32'd0);
        check({name, "_empty"}, {31'd0, bus.empty}, 32'd1);
        check({name, "_full"},  {31'd0, bus.full}, 32'd0);
        check({name, "_count"}, 32'(bus.count), 32'd0);
    endtask

    initial begin
        logic [7:0] d;
        int r;
        rst = 1'b1;
        bus.push_i  = 1'b0;
        bus.pop_i   = 1'b0;
        bus.data_in = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;

        do_op(1'b1, 1'b0, 8'h11, "push11", 0, 10);
        do_op(1'b1, 1'b0, 8'h22, "push22", 0, 10);
        do_op(1'b1, 1'b0, 8'h33, "push33", 0, 10);
        for (int i = 0; i < 3; i++) do_op(1'b0, 1'b1, 8'h00, "pop_seq", 0, 10);
        do_op(1'b0, 1'b1, 8'hFF, "pop_empty", 0, 10);

        for (int i = 0; i < 16; i++) do_op(1'b1, 1'b0, 8'(i), "fill", 0, 10);
        check("full_after_16", {31'd0, bus.full}, 32'd1);
        do_op(1'b1, 1'b0, 8'hAA, "overflow", 0, 10);
        while (model.size() > 0) do_op(1'b0, 1'b1, 8'h00, "drain", 0, 10);

        do_op(1'b1, 1'b0, 8'h5A, "push5a", 0, 10);
        do_op(1'b1, 1'b1, 8'hC3, "replace", 0, 10);
        do_op(1'b0, 1'b1, 8'h00, "pop_c3", 0, 10);
        do_op(1'b1, 1'b1, 8'h77, "replace_empty", 0, 10);
        do_op(1'b1, 1'b0, 8'h99, "hold_push", 20, 3);

        for (int i = 0; i < 120; i++) begin
            r = int'($urandom_range(0, 9));
            d = 8'($urandom);
            if (r < 5)      do_op(1'b1, 1'b0, d, "rnd_push", 0, 10);
            else if (r < 8) do_op(1'b0, 1'b1, d, "rnd_pop", 0, 10);
            else            do_op(1'b1, 1'b1, d, "rnd_replace", 0, 10);
        end

        while (model.size() > 0) do_op(1'b0, 1'b1, 8'h00, "drain2", 0, 10);
        for (int i = 0; i < 4; i++) do_op(1'b1, 1'b0, 8'(8'h40 + i), "pre_rst", 0, 10);
        model_op(1'b1, 1'b0, 8'h44, "push_fifth");
        @(negedge clk);
        bus.data_in = 8'h44;
        bus.push_i  = 1'b1;
        wait_level(1'b1, 20, "push_fifth_rise");
        @(negedge clk);
        check("count_before_rst", 32'(bus.count), 32'd5);
        rst = 1'b1;
        #1;
        check_reset_values("mid_rst");
        bus.push_i = 1'b0;
        model.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        do_op(1'b0, 1'b1, 8'h00, "pop_after_rst", 0, 10);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
